fifo_wr_arbiter: RTL
====================

// Module: fifo_wr_arbiter
// PURPOSE
//  Round-robin arbiter sharing the single async-FIFO write port (w_inc/w_data/full) among NUM_REQ
//  byte producers in the write clock domain. Grants one requester at a time, lets it stream a burst of
//  up to MAX_BURST bytes (ended early by req_last), and stalls all transfers while the FIFO reports full.
//  Sits between the producers and the FIFO write side; runs entirely on the FIFO write clock.
// PARAMETERS
//  NUM_REQ       4   number of requesters (2..8)
//  DATA_W        8   byte width; matches the FIFO w_data width
//  MAX_BURST     4   max bytes per grant (1..15)
//  IDLE_TIMEOUT  3   consecutive owner-req-low cycles in BUSY before ownership is released (1..7)
// PORTS
//  clk         in   1                 write-domain clock (same net as FIFO w_clk)
//  rst         in   1                 synchronous, active-high reset
//  req         in   NUM_REQ           per-requester byte valid; must hold with data until granted
//  req_data    in   NUM_REQ*DATA_W    requester i byte at [i*DATA_W +: DATA_W]
//  req_last    in   NUM_REQ           qualifies req: this byte ends the requester's burst
//  fifo_full   in   1                 FIFO full flag
//  w_inc       out  1                 FIFO write strobe
//  w_data      out  DATA_W            FIFO write data
//  grant       out  NUM_REQ           one-hot accept: byte of requester i consumed this cycle
//  owner       out  3                 index of current owner (valid when busy=1)
//  busy        out  1                 1 while in BUSY
// BEHAVIOUR
//  Reset: state=IDLE, rr_ptr=NUM_REQ-1 (so requester 0 wins first), owner=0, beat_cnt=0,
//   idle_cnt=0; outputs w_inc=0, grant=0, busy=0, w_data=0.
//  FSM IDLE:
//   - req==0: stay.
//   - else: owner <= first i with req[i]=1, searching rr_ptr+1, rr_ptr+2, ... modulo NUM_REQ;
//     beat_cnt <= 0; idle_cnt <= 0; -> BUSY.
//   - No transfer occurs in IDLE (1-cycle arbitration bubble per grant).
//  FSM BUSY:
//   - xfer = req[owner] & ~fifo_full (combinational).
//     w_inc = xfer; w_data = req_data[owner] when xfer, else 0; grant = xfer << owner.
//   - On xfer: beat_cnt++, idle_cnt <= 0.
//     If req_last[owner] or beat_cnt+1 == MAX_BURST: rr_ptr <= owner, -> IDLE.
//   - req[owner]=0: idle_cnt++. On idle_cnt+1 == IDLE_TIMEOUT: rr_ptr <= owner, -> IDLE
//     (burst abandoned; no data lost).
//   - fifo_full=1 with req[owner]=1: stall; beat_cnt and idle_cnt hold. Full never counts as idle.
//  Timing and invariants:
//   - Zero-latency path req/fifo_full -> w_inc/grant; all other state registered.
//   - At most one grant bit set; w_inc == |grant always.
//   - Requests from non-owners are ignored during BUSY.
//   - Full rising in the same cycle as the owner's byte blocks that byte.
//     FIFO overflow is impossible provided full is correct in the write domain.
//   - Fairness: each waiting requester is granted within NUM_REQ-1 other grants.
//   - Reset asserted mid-burst: next cycle is IDLE with all reset values.
//     Requester must re-present any byte not granted.
//   - owner index is zero-extended to 3 bits.
// TESTING
//  1 Reset, then req=4'b0101, no last, full=0:
//    grant sequence is bubble, R0 x4 beats, bubble, R2 x4, bubble, R0 ...
//    w_data equals the owner's byte on each w_inc.
//  2 R1 alone; req_last on its 2nd byte:
//    exactly 2 writes, then IDLE; with R3 now requesting, R3 wins next (rr_ptr=1).
//  3 R0 owning, fifo_full=1 for 5 cycles mid-burst:
//    w_inc=0 and grant=0 throughout; burst resumes at the same beat_cnt; no IDLE timeout fires.
//  4 R2 owning drops req for IDLE_TIMEOUT=3 cycles:
//    busy falls after the 3rd cycle; R2 re-raising req then waits behind other pending requesters.
//  5 All 4 requesting continuously, MAX_BURST=1:
//    grant order R0,R1,R2,R3,R0 with one bubble between each; no grant while full.
//  6 rst pulsed during a BUSY burst:
//    the next cycle has busy=0, w_inc=0, grant=0; first post-reset winner is the lowest-indexed requester.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter for an async FIFO.
// Shares the FIFO write side (w_inc/w_data/full) among NUM_REQ byte producers
// in the write clock domain. Each grant streams up to MAX_BURST bytes, ends
// early on req_last, and is released after IDLE_TIMEOUT idle cycles. Every
// grant costs one IDLE bubble cycle. The strobe, data and grant outputs are
// combinational from req/fifo_full so that a full flag rising in the same
// cycle as a byte blocks that byte.
module fifo_wr_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_W       = 8,
    parameter int MAX_BURST    = 4,
    parameter int IDLE_TIMEOUT = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    input  logic                      fifo_full,
    output logic                      w_inc,
    output logic [DATA_W-1:0]         w_data,
    output logic [NUM_REQ-1:0]        grant,
    output logic [2:0]                owner,
    output logic                      busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] owner_q;
    logic [IDX_W-1:0] rr_ptr;
    logic [3:0]       beat_cnt;
    logic [2:0]       idle_cnt;
    logic             busy_q;

    logic [IDX_W-1:0] pick;
    logic             pick_found;
    logic             own_req;
    logic             own_last;
    logic [DATA_W-1:0] own_data;
    logic             xfer;

    // Route the current owner's valid, last flag and byte out of the flat buses.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        own_req  = 1'b0;
        own_last = 1'b0;
        own_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner_q == IDX_W'(i)) begin
                own_req  = req[i];
                own_last = req_last[i];
                own_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Round-robin search: first requester above rr_ptr, then wrap to the lowest index.
    always_comb begin
        pick       = '0;
        pick_found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!pick_found && req[i] && (IDX_W'(i) > rr_ptr)) begin
                pick       = IDX_W'(i);
                pick_found = 1'b1;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!pick_found && req[i] && (IDX_W'(i) <= rr_ptr)) begin
                pick       = IDX_W'(i);
                pick_found = 1'b1;
            end
        end
    end

    // A byte moves only while busy, the owner holds a byte, and the FIFO has room.
    assign xfer   = (state == BUSY) && own_req && !fifo_full;
    assign w_inc  = xfer;
    assign w_data = xfer ? own_data : '0;

    // One-hot accept pulse towards the owning producer.
    always_comb begin
        grant = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant[i] = xfer && (owner_q == IDX_W'(i));
        end
    end

    assign owner = 3'(owner_q);
    assign busy  = busy_q;

    // Arbitration FSM: pick an owner in IDLE, count beats and idle cycles in BUSY.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            state    <= IDLE;
            rr_ptr   <= IDX_W'(NUM_REQ - 1);
            owner_q  <= '0;
            beat_cnt <= '0;
            idle_cnt <= '0;
            busy_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        owner_q  <= pick;
                        beat_cnt <= '0;
                        idle_cnt <= '0;
                        busy_q   <= 1'b1;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (xfer) begin
                        beat_cnt <= beat_cnt + 4'd1;
                        idle_cnt <= '0;
                        if (own_last || (beat_cnt == 4'(MAX_BURST - 1))) begin
                            rr_ptr <= owner_q;
                            busy_q <= 1'b0;
                            state  <= IDLE;
                        end
                    end else if (!own_req) begin
                        // Owner went quiet; give up the port after the timeout.
                        idle_cnt <= idle_cnt + 3'd1;
                        if (idle_cnt == 3'(IDLE_TIMEOUT - 1)) begin
                            rr_ptr <= owner_q;
                            busy_q <= 1'b0;
                            state  <= IDLE;
                        end
                    end
                    // Owner waiting on a full FIFO: both counters hold.
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule
